sudoku_load_dp: RTL and testbench
=================================

# sudoku_load_dp

Load datapath stage driven by the main controller (`main_FSM`). On a `start` pulse it accepts 81 puzzle digits over a valid/ready stream and writes them, in row-major order, into an internal cell buffer. It then returns a one-cycle `done` pulse to the controller. Downstream solver logic reads the buffer through a random-access read port.

## Interface
- `CELLS`, default 81: number of cells loaded per puzzle.
- `DW`, default 4: digit width in bits.
- `MAXV`, default 9: largest legal digit; 0 means an empty cell.
- `AW`, default `$clog2(CELLS)` (7): address width.

Ports:
- `clka`, input, 1: single system clock; all logic is on the rising edge.
- `restart`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle pulse from the controller that begins a load.
- `din_valid`, input, 1: upstream digit valid.
- `din`, input, DW: digit value.
- `din_ready`, output, 1: the block accepts a digit in this cycle.
- `busy`, output, 1: high while in LOAD or DONE.
- `done`, output, 1: one-cycle pulse after the last digit is written.
- `err`, output, 1: sticky flag for an out-of-range digit (see Configuration).
- `rd_addr`, input, AW: buffer read address.
- `rd_data`, output, DW: buffer read data.

## Operation
- The FSM has three states: IDLE, LOAD and DONE.
- **IDLE**
  - `din_ready` = 0.
  - `start` = 1 moves to LOAD, clears `addr` to 0 and clears `err`.
- **LOAD**
  - `din_ready` = 1.
  - A beat is accepted when `din_valid` and `din_ready` are both high. It writes `buf[addr]` = `din` and increments `addr`.
  - The beat accepted at `addr` == CELLS-1 moves to DONE. `addr` does not wrap; it holds at CELLS-1.
  - `din_valid` low stalls the load indefinitely, with no timeout.
- **DONE**
  - `done` = 1 and `din_ready` = 0.
  - The next cycle moves to IDLE unconditionally.
- `start` is ignored in LOAD and DONE. No restart of a load in progress is possible except through `restart`.
- `busy` = (state != IDLE).
- `rd_data` = `buf[rd_addr]` combinationally. For `rd_addr` >= CELLS, `rd_data` = 0.
- Reads of the address being written in the same cycle return the old value.
- Cell buffer contents are not reset. After `restart` they hold the previous values, or X from power-up.

## Timing
- Reset values: state = IDLE, `addr` = 0, `din_ready` = 0, `busy` = 0, `done` = 0, `err` = 0.
- `start` sampled at edge 0 gives `din_ready` = 1 from edge 0.
- With no stalls, beats are accepted at edges 1..81, and `done` is high for the cycle between edges 81 and 82.
- Minimum start-to-done latency is CELLS+1 cycles. Each stall cycle adds one.
- `done` is registered (decoded from state) and is exactly one cycle wide.
- `restart` asserted mid-load forces IDLE immediately, with no `done`. A new `start` begins again at address 0.
- `start` in the same cycle as a DONE-to-IDLE transition is ignored. The controller only re-issues `start` after returning to IDLE.

## Configuration
- Macro `SUDOKU_RANGE_CHECK_EN`.
- **Defined:**
  - An accepted `din` > MAXV is written as 0 and sets `err`.
  - `err` stays high until the next accepted `start` or `restart`.
  - Loading continues, and `done` still pulses.
- **Undefined:**
  - `din` is written unmodified.
  - `err` is tied to 0.

## Structure
- Shared package `sudoku_pkg` holds:
  - the state encoding IDLE = 2'b00, LOAD = 2'b01, DONE = 2'b10;
  - constants CELLS, DW, MAXV.
- Sub-module `sudoku_cell_buf` holds:
  - the CELLS×DW register file with one write port (`we`, `waddr`, `wdata`);
  - one combinational read port, including the out-of-range-read-returns-0 logic.
- The top level contains the FSM, the address counter and the range check.

## Test plan
- Reset, then `start`, then 81 back-to-back beats with `din` = i mod 10:
  - `done` is high exactly at cycle 82 after `start`;
  - `rd_data` at address 80 is 0 and at address 9 is 9;
  - `busy` is low after `done`.
- Same load with `din_valid` dropped for 5 cycles after beat 40: `done` moves to cycle 87, and beat 41 lands at address 41.
- `start` pulsed again at beat 30: it is ignored, `addr` continues, and exactly one `done` is produced.
- `restart` asserted at beat 50:
  - all outputs go to their reset values within the same cycle;
  - a new load overwrites addresses 0..80, and `done` fires once.
- With `SUDOKU_RANGE_CHECK_EN` defined, `din` = 12 at address 5:
  - `buf[5]` = 0 and `err` = 1 through `done`;
  - the next `start` clears `err`.
- With the macro undefined, the same stimulus gives `buf[5]` = 12 and `err` = 0.
- `rd_addr` = 81 or 127 gives `rd_data` = 0.

Source files
------------

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// sudoku_pkg: shared geometry constants and load-FSM state encoding.
// Rev 1.0
// ============================================================================
package sudoku_pkg;

  localparam int CELLS = 81;
  localparam int DW    = 4;
  localparam int MAXV  = 9;

  typedef logic [1:0] load_state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sudoku_cell_buf.sv
`default_nettype none
// ============================================================================
// sudoku_cell_buf: CELLS x DW register file, one write port, one async read.
// Rev 1.0
// ============================================================================
module sudoku_cell_buf #(
  parameter int CELLS = sudoku_pkg::CELLS,
  parameter int DW    = sudoku_pkg::DW,
  parameter int AW    = $clog2(CELLS)
) (
  input  logic          clka,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [CELLS];
  logic [DW-1:0] mem_d [CELLS];

  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < CELLS)) begin
      mem_d[waddr] = wdata;
    end
  end

  // Contents are deliberately not reset; they survive restart.
  always_ff @(posedge clka) begin
    mem_q <= mem_d;
  end

  // Addresses past the last cell read as an empty cell.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < CELLS) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sudoku_load_dp.sv
`default_nettype none
// ============================================================================
// sudoku_load_dp: streams CELLS digits row-major into the cell buffer, pulses
// done. Optional macro SUDOKU_RANGE_CHECK_EN zeroes digits > MAXV, sets err.
// Rev 1.0
// ============================================================================
module sudoku_load_dp #(
  parameter int CELLS = sudoku_pkg::CELLS,
  parameter int DW    = sudoku_pkg::DW,
  parameter int MAXV  = sudoku_pkg::MAXV,
  parameter int AW    = $clog2(CELLS)
) (
  input  logic          clka,
  input  logic          restart,
  input  logic          start,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          din_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  import sudoku_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam logic [DW-1:0] DIGIT_MAX = DW'(MAXV);

  load_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          beat_acc;
  logic          last_beat;
  logic [DW-1:0] wdata;

  assign din_ready = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign beat_acc  = din_valid && din_ready;
  assign last_beat = (addr_q == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        // The address parks on the last cell rather than wrapping.
        if (beat_acc) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef SUDOKU_RANGE_CHECK_EN
  logic digit_over;
  logic err_q, err_d;

  assign digit_over = (din > DIGIT_MAX);
  assign wdata      = digit_over ? '0 : din;
  assign err        = err_q;

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && start) begin
      err_d = 1'b0;
    end else if (beat_acc && digit_over) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  // Range is not enforced in this build; digits pass through untouched.
  logic unused_digit_over;

  assign unused_digit_over = (din > DIGIT_MAX);
  assign wdata             = din;
  assign err               = 1'b0;
`endif

  sudoku_cell_buf #(
    .CELLS (CELLS),
    .DW    (DW),
    .AW    (AW)
  ) u_cell_buf (
    .clka    (clka),
    .we      (beat_acc),
    .waddr   (addr_q),
    .wdata   (wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_sudoku_load_dp.sv
`default_nettype none
// ============================================================================
// tb_sudoku_load_dp: scoreboard bench for sudoku_load_dp.
// Rev 1.0
// ============================================================================
module tb_sudoku_load_dp;

  localparam int CELLS = 81;
  localparam int DW    = 4;
  localparam int AW    = 7;

`ifdef SUDOKU_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // Status word seen by the monitor: {din_ready, busy, done, err}.
  localparam int ST_READY = 8;
  localparam int ST_BUSY  = 4;

  logic          clka = 1'b0;
  logic          restart;
  logic          start;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  always #5 clka = ~clka;

  sudoku_load_dp dut (
    .clka      (clka),
    .restart   (restart),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  typedef struct {
    int    kind;   // 0 = read port, 1 = status word
    int    expv;
    string name;
  } chk_t;

  typedef struct {
    int s;
    int lat;
  } done_t;

  chk_t  chk_q [$];
  done_t done_q [$];

  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic chk_req  = 1'b0;

  logic [DW-1:0] model [CELLS];
  logic          err_model;

  always @(posedge clka) edge_cnt <= edge_cnt + 1;

  task automatic record(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  done_t mon_d;
  chk_t  mon_c;
  int    mon_act;

  always @(negedge clka) begin
    if (done) begin
      if (done_q.size() == 0) begin
        record("done_unexpected", int'(done), 0);
      end else begin
        mon_d = done_q.pop_front();
        record("done_latency", edge_cnt - mon_d.s + 1, mon_d.lat);
      end
    end
    if (chk_req && (chk_q.size() != 0)) begin
      mon_c   = chk_q.pop_front();
      mon_act = (mon_c.kind == 0) ? int'(rd_data)
                                  : int'({din_ready, busy, done, err});
      record(mon_c.name, mon_act, mon_c.expv);
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic push_chk(input int kind, input int expv, input string name);
    chk_t c;
    c.kind = kind;
    c.expv = expv;
    c.name = name;
    chk_q.push_back(c);
    chk_req = 1'b1;
  endtask

  task automatic st_chk(input int expv, input string name);
    tick();
    push_chk(1, expv, name);
  endtask

  task automatic rd_chk(input int a, input string name);
    logic [AW-1:0] aa;
    int            e;
    aa = AW'(a);
    e  = (a < CELLS) ? int'(model[a]) : 0;
    tick();
    rd_addr = aa;
    push_chk(0, e, name);
  endtask

  function automatic int pat_val(input int p, input int i);
    case (p)
      0:       return i % 10;
      1:       return (i * 3 + 1) % 10;
      2:       return (i + 5) % 10;
      3:       return (i * 7 + 3) % 10;
      default: return (i == 5) ? 12 : i % 10;
    endcase
  endfunction

  task automatic run_load(input int pat, input int stall_after, input int start_again,
                          input int restart_at, input int chk_at, input bit exp_done,
                          input int exp_lat);
    done_t d;
    int    v;
    tick();
    start     = 1'b1;
    din_valid = 1'b0;
    err_model = 1'b0;
    if (exp_done) begin
      d.s   = edge_cnt + 1;
      d.lat = exp_lat;
      done_q.push_back(d);
    end
    for (int i = 0; i < CELLS; i++) begin
      tick();
      start     = (i == start_again);
      din_valid = 1'b1;
      v         = pat_val(pat, i);
      din       = DW'(v);
      if (i == chk_at)
        push_chk(1, ST_READY + ST_BUSY + int'(err_model), $sformatf("status_load_%0d", i));
      if (RC && (v > 9)) begin
        model[i]  = '0;
        err_model = 1'b1;
      end else begin
        model[i] = DW'(v);
      end
      if (i == restart_at) begin
        tick();
        restart   = 1'b1;
        din_valid = 1'b0;
        start     = 1'b0;
        err_model = 1'b0;
        push_chk(1, 0, "status_restart");
        tick();
        restart = 1'b0;
        return;
      end
      if (i == stall_after) begin
        repeat (5) begin
          tick();
          din_valid = 1'b0;
          start     = 1'b0;
        end
      end
    end
    tick();
    din_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int w = 0; (w < 10) && (done_q.size() != 0); w++) tick();
    record(name, done_q.size(), 0);
    done_q.delete();
  endtask

  initial begin
    restart   = 1'b1;
    start     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    rd_addr   = '0;
    err_model = 1'b0;
    repeat (3) tick();
    push_chk(1, 0, "status_reset");
    tick();
    restart = 1'b0;
    tick();

    // Back-to-back load, digit = i mod 10
    run_load(0, -1, -1, -1, 0, 1'b1, 82);
    wait_done("done_seen_plain");
    st_chk(0, "status_after_done");
    rd_chk(80, "rd_80");
    rd_chk(9, "rd_9");
    rd_chk(81, "rd_oob_81");
    rd_chk(127, "rd_oob_127");

    // Five-cycle stall after beat 40
    run_load(1, 40, -1, -1, -1, 1'b1, 87);
    wait_done("done_seen_stall");
    rd_chk(40, "rd_stall_40");
    rd_chk(41, "rd_stall_41");
    rd_chk(42, "rd_stall_42");

    // Second start mid-load is ignored
    run_load(2, -1, 30, -1, -1, 1'b1, 82);
    wait_done("done_seen_restart_ignored");
    rd_chk(29, "rd_dup_29");
    rd_chk(30, "rd_dup_30");
    rd_chk(31, "rd_dup_31");
    rd_chk(80, "rd_dup_80");

    // Restart at beat 50, then a fresh full load
    run_load(3, -1, -1, 50, -1, 1'b0, 0);
    wait_done("done_none_after_restart");
    run_load(0, -1, -1, -1, -1, 1'b1, 82);
    wait_done("done_seen_reload");
    for (int a = 0; a < CELLS; a++) rd_chk(a, $sformatf("rd_reload_%0d", a));

    // Out-of-range digit at address 5
    run_load(4, -1, -1, -1, 10, 1'b1, 82);
    wait_done("done_seen_range");
    st_chk(int'(RC), "status_err_after_done");
    rd_chk(4, "rd_range_4");
    rd_chk(5, "rd_range_5");
    rd_chk(6, "rd_range_6");

    // Next start clears err
    run_load(0, -1, -1, -1, 0, 1'b1, 82);
    wait_done("done_seen_clear");
    st_chk(0, "status_final");
    tick();
    tick();
    record("scoreboard_drained", chk_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
